// File: rtl/muldiv_unit_pkg.sv
// Shared control encodings for the execute stage: ALU operation codes and
// the multiply/divide unit operation codes.
package muldiv_unit_pkg;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_XOR  = 4'd4;
    localparam logic [3:0] ALUOP_NOR  = 4'd5;
    localparam logic [3:0] ALUOP_SLT  = 4'd6;
    localparam logic [3:0] ALUOP_SLTU = 4'd7;
    localparam logic [3:0] ALUOP_SLL  = 4'd8;
    localparam logic [3:0] ALUOP_SRL  = 4'd9;
    localparam logic [3:0] ALUOP_SRA  = 4'd10;
    localparam logic [3:0] ALUOP_LUI  = 4'd11;

    localparam logic [2:0] MDUOP_MULT  = 3'd0;
    localparam logic [2:0] MDUOP_MULTU = 3'd1;
    localparam logic [2:0] MDUOP_DIV   = 3'd2;
    localparam logic [2:0] MDUOP_DIVU  = 3'd3;
    localparam logic [2:0] MDUOP_MTHI  = 3'd4;
    localparam logic [2:0] MDUOP_MTLO  = 3'd5;

endpackage

// File: rtl/mdu_signfix.sv
// Sign handling around the unsigned iterative core: operand magnitudes on the
// way in, two's-complement correction of product/quotient/remainder on the way out.
module mdu_signfix #(
    parameter int WIDTH = 32
) (
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic                 a_neg,
    output logic                 b_neg,
    input  logic [2*WIDTH-1:0]   prod,
    input  logic                 prod_neg,
    output logic [2*WIDTH-1:0]   prod_fix,
    input  logic [WIDTH-1:0]     quo,
    input  logic                 quo_neg,
    output logic [WIDTH-1:0]     quo_fix,
    input  logic [WIDTH-1:0]     rem,
    input  logic                 rem_neg,
    output logic [WIDTH-1:0]     rem_fix
);

    always_comb begin
        a_neg    = signed_op & a[WIDTH-1];
        b_neg    = signed_op & b[WIDTH-1];
        a_mag    = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag    = b_neg ? (~b + WIDTH'(1)) : b;
        prod_fix = prod_neg ? (~prod + (2*WIDTH)'(1)) : prod;
        quo_fix  = quo_neg ? (~quo + WIDTH'(1)) : quo;
        rem_fix  = rem_neg ? (~rem + WIDTH'(1)) : rem;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// subtract-shift step per cycle on operand magnitudes, signs fixed at the end.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   work;
    logic [2*WIDTH-1:0]   work_next;
    logic [WIDTH-1:0]     operand;
    logic                 res_neg;
    logic                 rem_neg;
    logic                 div_zero;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 a_neg;
    logic                 b_neg;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;

    assign signed_op = (op == MDUOP_MULT) || (op == MDUOP_DIV);

    // The fix-up side looks at work_next so the last step's result is written in the same edge.
    mdu_signfix #(.WIDTH(WIDTH)) u_signfix (
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .prod      (work_next),
        .prod_neg  (res_neg),
        .prod_fix  (prod_fix),
        .quo       (work_next[WIDTH-1:0]),
        .quo_neg   (res_neg),
        .quo_fix   (quo_fix),
        .rem       (work_next[2*WIDTH-1:WIDTH]),
        .rem_neg   (rem_neg),
        .rem_fix   (rem_fix)
    );

    // work holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : '0);
        div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        work_next = work;
        if (state == RUN_MUL) begin
            work_next = {mul_sum, work[WIDTH-1:1]};
        end else if (state == RUN_DIV) begin
            if (!div_diff[WIDTH])
                work_next = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            else
                work_next = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            work     <= '0;
            operand  <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                MDUOP_MULT, MDUOP_MULTU: begin
                                    state   <= RUN_MUL;
                                    busy    <= 1'b1;
                                    count   <= CNT_W'(WIDTH);
                                    work    <= {{WIDTH{1'b0}}, a_mag};
                                    operand <= b_mag;
                                    res_neg <= a_neg ^ b_neg;
                                end
                                MDUOP_DIV, MDUOP_DIVU: begin
                                    state    <= RUN_DIV;
                                    busy     <= 1'b1;
                                    count    <= CNT_W'(WIDTH);
                                    work     <= {{WIDTH{1'b0}}, a_mag};
                                    operand  <= b_mag;
                                    res_neg  <= a_neg ^ b_neg;
                                    rem_neg  <= a_neg;
                                    div_zero <= (b == '0);
                                end
                                MDUOP_MTHI: hi <= a;
                                MDUOP_MTLO: lo <= a;
                                default: ;
                            endcase
                        end
                    end
                    RUN_MUL, RUN_DIV: begin
                        work  <= work_next;
                        count <= count - 1'b1;
                        if (count == CNT_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            if (state == RUN_MUL) begin
                                {hi, lo} <= prod_fix;
                            end else begin
                                // A zero divisor leaves |a| in the remainder, so hi already reads back as a.
                                hi <= rem_fix;
                                lo <= div_zero ? '1 : quo_fix;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed corner cases plus
// randomized op sequences compared against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          vector_count = 0;
    int          miss_count = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Architectural result of one op as {hi, lo}, from ordinary integer arithmetic.
    function automatic logic [63:0] refModel(input logic [2:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b,
                                             input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(f_a));
        sb = longint'($signed(f_b));
        ua = {32'd0, f_a};
        ub = {32'd0, f_b};
        case (f_op)
            MDUOP_MULT:  return 64'(sa * sb);
            MDUOP_MULTU: return ua * ub;
            MDUOP_DIV: begin
                if (f_b == 32'd0) return {f_a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MDUOP_DIVU: begin
                if (f_b == 32'd0) return {f_a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            MDUOP_MTHI: return {f_a, cur_lo};
            MDUOP_MTLO: return {cur_hi, f_a};
            default:    return {cur_hi, cur_lo};
        endcase
    endfunction

    task automatic launch(input logic [2:0] l_op, input logic [31:0] l_a, input logic [31:0] l_b);
        op    = l_op;
        a     = l_a;
        b     = l_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] s_op, input logic [31:0] s_a, input logic [31:0] s_b);
        logic [63:0] expected;
        int          lat;
        expected = refModel(s_op, s_a, s_b, model_hi, model_lo);
        launch(s_op, s_a, s_b);
        if (s_op == MDUOP_MTHI || s_op == MDUOP_MTLO) begin
            checkOutput({tag, " hi:lo"}, {hi, lo}, expected);
            checkOutput({tag, " busy/done"}, {62'd0, busy, done}, 64'd0);
        end else begin
            checkOutput({tag, " busy"}, {63'd0, busy}, 64'd1);
            waitDone(lat);
            checkOutput({tag, " latency"}, 64'(lat), 64'd32);
            checkOutput({tag, " hi:lo"}, {hi, lo}, expected);
            checkOutput({tag, " busy at done"}, {63'd0, busy}, 64'd0);
        end
        {model_hi, model_lo} = expected;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          done_seen;
        logic [63:0] expected;
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset hi", {32'd0, hi}, 64'd0);
        checkOutput("reset lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("mult -3*7", MDUOP_MULT, 32'hFFFF_FFFD, 32'd7);
        checkOutput("mult -3*7 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        checkOutput("done pulse width", {63'd0, done}, 64'd0);
        applyStimulus("multu max*max", MDUOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        applyStimulus("div -7/2", MDUOP_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div -7/2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus("div minneg/-1", MDUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div minneg const", {hi, lo}, 64'h0000_0000_8000_0000);
        applyStimulus("divu by zero", MDUOP_DIVU, 32'h0000_1234, 32'd0);
        checkOutput("divu zero const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        applyStimulus("div neg by zero", MDUOP_DIV, 32'hFFFF_FF00, 32'd0);

        // Flush mid-MULT: busy drops, no done ever appears, HI/LO keep preloaded values.
        applyStimulus("mthi preload", MDUOP_MTHI, 32'h1111_1111, 32'd0);
        applyStimulus("mtlo preload", MDUOP_MTLO, 32'h2222_2222, 32'd0);
        launch(MDUOP_MULT, 32'h0001_2345, 32'd678);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush busy", {63'd0, busy}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        checkOutput("flush no done", 64'(done_seen), 64'd0);
        checkOutput("flush hi:lo", {hi, lo}, {model_hi, model_lo});

        flush = 1'b1;
        launch(MDUOP_MTHI, 32'hDEAD_BEEF, 32'd0);
        launch(MDUOP_DIVU, 32'd100, 32'd3);
        flush = 1'b0;
        checkOutput("flush beats start busy", {63'd0, busy}, 64'd0);
        checkOutput("flush beats start hi", {32'd0, hi}, {32'd0, model_hi});

        launch(MDUOP_DIV, 32'd1000, 32'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst mid div hi:lo", {hi, lo}, 64'd0);
        checkOutput("rst mid div busy/done", {62'd0, busy, done}, 64'd0);
        model_hi = '0;
        model_lo = '0;

        // A start arriving while busy is dropped, not queued.
        expected = refModel(MDUOP_MULT, 32'd5, 32'd6, model_hi, model_lo);
        launch(MDUOP_MULT, 32'd5, 32'd6);
        repeat (2) @(negedge clk);
        launch(MDUOP_MTLO, 32'hA5A5_A5A5, 32'd0);
        checkOutput("mtlo while busy lo", {32'd0, lo}, {32'd0, model_lo});
        checkOutput("mtlo while busy busy", {63'd0, busy}, 64'd1);
        waitDone(lat);
        checkOutput("mult after ignore latency", 64'(lat), 64'd29);
        checkOutput("mult after ignore hi:lo", {hi, lo}, expected);
        {model_hi, model_lo} = expected;
        applyStimulus("mtlo idle", MDUOP_MTLO, 32'hA5A5_A5A5, 32'd0);
        checkOutput("mtlo idle const", {32'd0, lo}, 64'h0000_0000_A5A5_A5A5);

        applyStimulus("b2b first", MDUOP_DIVU, 32'd100, 32'd7);
        applyStimulus("b2b second", MDUOP_MULTU, 32'h0000_FFFF, 32'h0001_0001);

        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 5));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_b = 32'($urandom_range(1, 20));
                3: r_a = 32'h8000_0000;
                default: ;
            endcase
            applyStimulus("random", r_op, r_a, r_b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8..64, even.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request: launch op this cycle.
REQ-006 SHALL have port op  input  3  MDUOP_MULT/MULTU/DIV/DIVU/MTHI/MTLO.
REQ-007 SHALL have port a  input  WIDTH  operand A (multiplicand/dividend/MTHI-MTLO source).
REQ-008 SHALL have port b  input  WIDTH  operand B (multiplier/divisor).
REQ-009 SHALL have port flush  input  1  pipeline abort of in-flight op.
REQ-010 SHALL have port busy  output  1  iterative op in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse: hi/lo just updated by MULT/DIV.
REQ-012 SHALL have port hi  output  WIDTH  HI register.
REQ-013 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-014 SHALL implement FSM states IDLE, RUN_MUL, RUN_DIV.
REQ-015 SHALL accept start only in IDLE with flush=0; start while busy or during flush is ignored, with no queueing.
REQ-016 SHALL on accepted MULT/MULTU/DIV/DIVU latch operand magnitudes and sign flags, load counter=WIDTH, and enter RUN_MUL/RUN_DIV, with busy=1 from the next cycle.
REQ-017 SHALL perform one shift-add (MUL) or one restoring subtract-shift (DIV) step per cycle while running, decrementing the counter.
REQ-018 SHALL, on the edge that retires the last step (the WIDTH-th edge after acceptance), write hi/lo, return to IDLE, drop busy, and assert done for exactly one cycle.
REQ-019 SHALL make a new start legal in the same cycle done=1.
REQ-020 SHALL produce for MULT/MULTU hi:lo = full 2*WIDTH product, signed for MULT and unsigned for MULTU.
REQ-021 SHALL produce for DIV/DIVU lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign (DIV).
REQ-022 SHALL on divide-by-zero, for DIV and DIVU, set lo = all ones and hi = a, with the same latency and a done pulse.
REQ-023 SHALL on DIV of most-negative by -1 set lo = most-negative and hi = 0, with no error flag.
REQ-024 SHALL on MTHI/MTLO accepted in IDLE write hi or lo = a at that edge, with busy and done staying 0.
REQ-025 SHALL on flush=1 in any state return to IDLE at the next edge, with busy=0, no done, and hi/lo unchanged.
REQ-026 SHALL give flush priority over start in the same cycle.
REQ-027 SHALL ensure hi/lo change only per REQ-018, REQ-022, REQ-024, or reset.

Reset
REQ-028 SHALL on rst=1 at a clock edge set state=IDLE, busy=0, done=0, hi=0, lo=0, and counter=0, aborting any op mid-flight.
REQ-029 SHALL give rst priority over flush and start.

Structure
REQ-030 SHALL keep the MDUOP_* encodings (3-bit) in the shared control define file alongside the ALUOP_* codes.
REQ-031 SHALL keep FSM state encodings local to the module.
REQ-032 SHALL place operand conditioning and result sign correction (two's-complement negate of WIDTH and 2*WIDTH values) in one combinational sub-module, mdu_signfix.
REQ-033 SHALL use no multiplier or divider operators in RTL; all arithmetic is iterative.

Verification (WIDTH=32)
REQ-034 SHALL check MULT a=0xFFFFFFFD, b=7 -> after 32 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 SHALL check DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 SHALL check DIVU a=0x00001234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234, done after 32 cycles.
REQ-037 SHALL check MULT started, then flush at cycle 10 -> busy=0 next cycle, no done, hi/lo hold prior values; rst at cycle 5 of DIV -> hi=lo=0, busy=0.
REQ-038 SHALL check start with MTLO a=0xA5A5A5A5 while busy -> ignored; the same start in IDLE -> lo=0xA5A5A5A5 next cycle, busy=0, done=0.
REQ-039 SHALL check back-to-back ops with start in the done cycle -> second op accepted, with its done exactly 32 cycles later.
